// File: rtl/spi_master.sv
// SPI master: one WIDTH-bit word per tx handshake, MSB first, any CPOL/CPHA mode.
// Consecutive words with tx_last=0 keep cs_n asserted and skip the SETUP phase.
module spi_master #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 4,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_last_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             busy_o,
    output logic             sclk_o,
    output logic             mosi_o,
    input  logic             miso_i,
    output logic             cs_n_o
);

    localparam int unsigned EDGES  = 2 * WIDTH;
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGE_W = $clog2(EDGES);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]  rx_data_q, rx_data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              leading, sample_en, shift_en;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        div_d      = '0;
        edge_d     = edge_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        last_d     = last_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_valid_d = done_q;
        rx_data_d  = done_q ? rx_shift_q : rx_data_q;
        leading    = 1'b0;
        sample_en  = 1'b0;
        shift_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid_i) begin
                    last_d = tx_last_i;
                    cs_n_d = 1'b0;
                    edge_d = '0;
                    // Mode 0 presents the MSB before the first edge; mode 1 on it
                    if (CPHA == 1'b0) begin
                        mosi_d     = tx_data_i[WIDTH-1];
                        tx_shift_d = {tx_data_i[WIDTH-2:0], 1'b0};
                    end else begin
                        tx_shift_d = tx_data_i;
                    end
                    state_d = cs_n_q ? SETUP : XFER;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = XFER;
                    edge_d  = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            XFER: begin
                if (div_q == DIV_LAST) begin
                    sclk_d    = ~sclk_q;
                    edge_d    = edge_q + EDGE_W'(1);
                    leading   = ~edge_q[0];
                    sample_en = leading ^ CPHA;
                    shift_en  = CPHA ? leading : (!leading && (edge_q != EDGE_LAST));
                    if (sample_en) begin
                        rx_shift_d = {rx_shift_q[WIDTH-2:0], miso_i};
                    end
                    if (shift_en) begin
                        mosi_d     = tx_shift_q[WIDTH-1];
                        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                    end
                    if (edge_q == EDGE_LAST) begin
                        done_d  = 1'b1;
                        edge_d  = '0;
                        state_d = last_q ? HOLD : IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
    assign sclk_o     = sclk_q;
    assign mosi_o     = mosi_q;
    assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: mode 0 and mode 3 at CLK_DIV=2, plus a CLK_DIV=1 instance.
`timescale 1ns/1ps
module tb_spi_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Mode 0, CLK_DIV=2, loopback
    logic [7:0] tx_data_0 = '0;
    logic       tx_last_0 = 1'b0, tx_valid_0 = 1'b0;
    logic       tx_ready_0, rx_valid_0, busy_0, sclk_0, mosi_0, miso_0, cs_n_0;
    logic [7:0] rx_data_0;
    assign miso_0 = mosi_0;

    // Mode 3, CLK_DIV=2, bench-modelled slave
    logic [7:0] tx_data_3 = '0;
    logic       tx_last_3 = 1'b0, tx_valid_3 = 1'b0, miso_3 = 1'b0;
    logic       tx_ready_3, rx_valid_3, busy_3, sclk_3, mosi_3, cs_n_3;
    logic [7:0] rx_data_3;

    // Mode 0, CLK_DIV=1, loopback
    logic [7:0] tx_data_1 = '0;
    logic       tx_last_1 = 1'b0, tx_valid_1 = 1'b0;
    logic       tx_ready_1, rx_valid_1, busy_1, sclk_1, mosi_1, miso_1, cs_n_1;
    logic [7:0] rx_data_1;
    assign miso_1 = mosi_1;

    spi_master #(.WIDTH(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data_0), .tx_last_i(tx_last_0),
        .tx_valid_i(tx_valid_0), .tx_ready_o(tx_ready_0), .rx_data_o(rx_data_0),
        .rx_valid_o(rx_valid_0), .busy_o(busy_0), .sclk_o(sclk_0), .mosi_o(mosi_0),
        .miso_i(miso_0), .cs_n_o(cs_n_0));

    spi_master #(.WIDTH(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data_3), .tx_last_i(tx_last_3),
        .tx_valid_i(tx_valid_3), .tx_ready_o(tx_ready_3), .rx_data_o(rx_data_3),
        .rx_valid_o(rx_valid_3), .busy_o(busy_3), .sclk_o(sclk_3), .mosi_o(mosi_3),
        .miso_i(miso_3), .cs_n_o(cs_n_3));

    spi_master #(.WIDTH(8), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data_1), .tx_last_i(tx_last_1),
        .tx_valid_i(tx_valid_1), .tx_ready_o(tx_ready_1), .rx_data_o(rx_data_1),
        .rx_valid_o(rx_valid_1), .busy_o(busy_1), .sclk_o(sclk_1), .mosi_o(mosi_1),
        .miso_i(miso_1), .cs_n_o(cs_n_1));

    task automatic test_reset();
        rst_n = 1'b0;
        tx_data_0 = 8'hFF; tx_last_0 = 1'b1; tx_valid_0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cs_n_0 !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n_0); end
        n_cmp++; if (sclk_0 !== 1'b0) begin n_bad++; $display("FAIL reset_sclk_m0: got %b want 0", sclk_0); end
        n_cmp++; if (mosi_0 !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi_0); end
        n_cmp++; if (rx_data_0 !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data_0); end
        n_cmp++; if (rx_valid_0 !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid_0); end
        n_cmp++; if (busy_0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_0); end
        n_cmp++; if (tx_ready_0 !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready_0); end
        n_cmp++; if (sclk_3 !== 1'b1) begin n_bad++; $display("FAIL reset_sclk_m3: got %b want 1", sclk_3); end
        @(negedge clk);
        tx_valid_0 = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy_0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid_ignored_busy: got %b want 0", busy_0); end
        n_cmp++; if (cs_n_0 !== 1'b1) begin n_bad++; $display("FAIL reset_valid_ignored_cs: got %b want 1", cs_n_0); end
    endtask

    task automatic test_mode0();
        int edges = 0, first_rise = 0, last_edge = 0, rxv_cyc = 0, cs_hi = 0, nrx = 0;
        logic [7:0] bits = '0, rxd = '0;
        logic prev;
        @(negedge clk);
        tx_data_0 = 8'hA5; tx_last_0 = 1'b1; tx_valid_0 = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (cs_n_0 !== 1'b0) begin n_bad++; $display("FAIL m0_cs_low_t1: got %b want 0", cs_n_0); end
        n_cmp++; if (mosi_0 !== 1'b1) begin n_bad++; $display("FAIL m0_mosi_msb_setup: got %b want 1", mosi_0); end
        n_cmp++; if (tx_ready_0 !== 1'b0) begin n_bad++; $display("FAIL m0_ready_setup: got %b want 0", tx_ready_0); end
        n_cmp++; if (busy_0 !== 1'b1) begin n_bad++; $display("FAIL m0_busy_setup: got %b want 1", busy_0); end
        @(negedge clk);
        tx_valid_0 = 1'b0;
        prev = sclk_0;
        for (int k = 2; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (sclk_0 !== prev) begin
                edges++;
                last_edge = k;
                if (sclk_0 === 1'b1) begin
                    bits = {bits[6:0], mosi_0};
                    if (first_rise == 0) first_rise = k;
                end
            end
            prev = sclk_0;
            if (rx_valid_0 === 1'b1) begin nrx++; rxv_cyc = k; rxd = rx_data_0; end
            if (cs_n_0 === 1'b1 && cs_hi == 0) cs_hi = k;
        end
        n_cmp++; if (first_rise != 5) begin n_bad++; $display("FAIL m0_first_rise: got T+%0d want T+5", first_rise); end
        n_cmp++; if (edges != 16) begin n_bad++; $display("FAIL m0_edge_count: got %0d want 16", edges); end
        n_cmp++; if (last_edge != 35) begin n_bad++; $display("FAIL m0_last_edge: got T+%0d want T+35", last_edge); end
        n_cmp++; if (nrx != 1) begin n_bad++; $display("FAIL m0_rx_pulses: got %0d want 1", nrx); end
        n_cmp++; if (rxv_cyc != 36) begin n_bad++; $display("FAIL m0_rx_valid_time: got T+%0d want T+36", rxv_cyc); end
        n_cmp++; if (rxd !== 8'hA5) begin n_bad++; $display("FAIL m0_rx_data: got %h want a5", rxd); end
        n_cmp++; if (bits !== 8'hA5) begin n_bad++; $display("FAIL m0_mosi_bits: got %h want a5", bits); end
        n_cmp++; if (cs_hi != 37) begin n_bad++; $display("FAIL m0_cs_rise: got T+%0d want T+37", cs_hi); end
        n_cmp++; if (sclk_0 !== 1'b0) begin n_bad++; $display("FAIL m0_sclk_idle: got %b want 0", sclk_0); end
        n_cmp++; if (mosi_0 !== 1'b0) begin n_bad++; $display("FAIL m0_mosi_idle: got %b want 0", mosi_0); end
    endtask

    task automatic test_mode3();
        int edges = 0, first_fall = 0, cs_hi = 0, nrx = 0;
        logic [7:0] bits = '0, rxd = '0, slv = 8'h3C;
        logic prev;
        @(negedge clk);
        tx_data_3 = 8'hC3; tx_last_3 = 1'b1; tx_valid_3 = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (sclk_3 !== 1'b1) begin n_bad++; $display("FAIL m3_sclk_idle_start: got %b want 1", sclk_3); end
        @(negedge clk);
        tx_valid_3 = 1'b0;
        prev = sclk_3;
        for (int k = 2; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (sclk_3 !== prev) begin
                edges++;
                if (sclk_3 === 1'b0) begin
                    miso_3 = slv[7];
                    slv = {slv[6:0], 1'b0};
                    if (first_fall == 0) first_fall = k;
                end else begin
                    bits = {bits[6:0], mosi_3};
                end
            end
            prev = sclk_3;
            if (rx_valid_3 === 1'b1) begin nrx++; rxd = rx_data_3; end
            if (cs_n_3 === 1'b1 && cs_hi == 0) cs_hi = k;
        end
        n_cmp++; if (first_fall != 5) begin n_bad++; $display("FAIL m3_first_edge: got T+%0d want T+5", first_fall); end
        n_cmp++; if (edges != 16) begin n_bad++; $display("FAIL m3_edge_count: got %0d want 16", edges); end
        n_cmp++; if (bits !== 8'hC3) begin n_bad++; $display("FAIL m3_mosi_bits: got %h want c3", bits); end
        n_cmp++; if (nrx != 1) begin n_bad++; $display("FAIL m3_rx_pulses: got %0d want 1", nrx); end
        n_cmp++; if (rxd !== 8'h3C) begin n_bad++; $display("FAIL m3_rx_data: got %h want 3c", rxd); end
        n_cmp++; if (cs_hi != 37) begin n_bad++; $display("FAIL m3_cs_rise: got T+%0d want T+37", cs_hi); end
        n_cmp++; if (sclk_3 !== 1'b1) begin n_bad++; $display("FAIL m3_sclk_idle_end: got %b want 1", sclk_3); end
    endtask

    task automatic test_back_to_back();
        int acc = 0, edges = 0, nrx = 0, cs_rise = 0, cs_fall = 0;
        int edge_cyc[40];
        logic [7:0] rxd[2];
        logic prev, prev_cs, will_acc;
        rxd[0] = '0; rxd[1] = '0;
        for (int i = 0; i < 40; i++) edge_cyc[i] = 0;
        prev = sclk_0;
        prev_cs = cs_n_0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (acc == 0) begin tx_data_0 = 8'h11; tx_last_0 = 1'b0; tx_valid_0 = 1'b1; end
            else if (acc == 1) begin tx_data_0 = 8'h22; tx_last_0 = 1'b1; tx_valid_0 = 1'b1; end
            else tx_valid_0 = 1'b0;
            will_acc = tx_valid_0 && tx_ready_0;
            @(posedge clk);
            #1;
            if (will_acc) acc++;
            if (sclk_0 !== prev) begin
                if (edges < 40) edge_cyc[edges] = k;
                edges++;
            end
            prev = sclk_0;
            if (cs_n_0 === 1'b1 && prev_cs === 1'b0) cs_rise++;
            if (cs_n_0 === 1'b0 && prev_cs === 1'b1) cs_fall++;
            prev_cs = cs_n_0;
            if (rx_valid_0 === 1'b1) begin
                if (nrx < 2) rxd[nrx] = rx_data_0;
                nrx++;
            end
        end
        tx_valid_0 = 1'b0;
        n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
        n_cmp++; if (edges != 32) begin n_bad++; $display("FAIL b2b_edges: got %0d want 32", edges); end
        n_cmp++; if (edge_cyc[16] - edge_cyc[15] != 3) begin n_bad++; $display("FAIL b2b_no_setup_gap: got %0d want 3", edge_cyc[16] - edge_cyc[15]); end
        n_cmp++; if (nrx != 2) begin n_bad++; $display("FAIL b2b_rx_pulses: got %0d want 2", nrx); end
        n_cmp++; if (rxd[0] !== 8'h11) begin n_bad++; $display("FAIL b2b_rx0: got %h want 11", rxd[0]); end
        n_cmp++; if (rxd[1] !== 8'h22) begin n_bad++; $display("FAIL b2b_rx1: got %h want 22", rxd[1]); end
        n_cmp++; if (cs_rise != 1) begin n_bad++; $display("FAIL b2b_cs_rises: got %0d want 1", cs_rise); end
        n_cmp++; if (cs_fall != 1) begin n_bad++; $display("FAIL b2b_cs_falls: got %0d want 1", cs_fall); end
    endtask

    task automatic test_reset_abort();
        int edges = 0, nrx = 0, cs_low = 0, busy_cyc = 0;
        logic prev;
        @(negedge clk);
        tx_data_0 = 8'hA5; tx_last_0 = 1'b1; tx_valid_0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid_0 = 1'b0;
        #1;
        prev = sclk_0;
        for (int k = 0; k < 40 && edges < 7; k++) begin
            @(posedge clk);
            #1;
            if (sclk_0 !== prev) edges++;
            prev = sclk_0;
        end
        n_cmp++; if (edges != 7) begin n_bad++; $display("FAIL abort_reach_bit4: got %0d edges want 7", edges); end
        n_cmp++; if (busy_0 !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy_0); end
        @(negedge clk);
        rst_n = 1'b0;
        tx_valid_0 = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (cs_n_0 !== 1'b1) begin n_bad++; $display("FAIL abort_cs_n: got %b want 1", cs_n_0); end
        n_cmp++; if (sclk_0 !== 1'b0) begin n_bad++; $display("FAIL abort_sclk: got %b want 0", sclk_0); end
        n_cmp++; if (mosi_0 !== 1'b0) begin n_bad++; $display("FAIL abort_mosi: got %b want 0", mosi_0); end
        n_cmp++; if (busy_0 !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_0); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tx_valid_0 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (rx_valid_0 === 1'b1) nrx++;
            if (cs_n_0 !== 1'b1) cs_low++;
            if (busy_0 !== 1'b0) busy_cyc++;
        end
        n_cmp++; if (nrx != 0) begin n_bad++; $display("FAIL abort_no_rx_valid: got %0d pulses want 0", nrx); end
        n_cmp++; if (cs_low != 0) begin n_bad++; $display("FAIL abort_cs_stays_high: got %0d low cycles want 0", cs_low); end
        n_cmp++; if (busy_cyc != 0) begin n_bad++; $display("FAIL abort_idle_after: got %0d busy cycles want 0", busy_cyc); end
        n_cmp++; if (tx_ready_0 !== 1'b1) begin n_bad++; $display("FAIL abort_tx_ready: got %b want 1", tx_ready_0); end
    endtask

    task automatic test_div1();
        int acc = 0, nrx = 0, rises = 0, viol = 0;
        int rise_cyc[20];
        logic [7:0] rxd[2];
        logic prev, will_acc;
        rxd[0] = '0; rxd[1] = '0;
        for (int i = 0; i < 20; i++) rise_cyc[i] = 0;
        prev = sclk_1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (acc == 0) begin tx_data_1 = 8'h96; tx_last_1 = 1'b1; tx_valid_1 = 1'b1; end
            else if (acc == 1) begin tx_data_1 = 8'h5A; tx_last_1 = 1'b1; tx_valid_1 = 1'b1; end
            else tx_valid_1 = 1'b0;
            will_acc = tx_valid_1 && tx_ready_1;
            @(posedge clk);
            #1;
            if (will_acc) acc++;
            if (busy_1 === tx_ready_1) viol++;
            if (sclk_1 === 1'b1 && prev === 1'b0) begin
                if (rises < 20) rise_cyc[rises] = k;
                rises++;
            end
            prev = sclk_1;
            if (rx_valid_1 === 1'b1) begin
                if (nrx < 2) rxd[nrx] = rx_data_1;
                nrx++;
            end
        end
        tx_valid_1 = 1'b0;
        n_cmp++; if (acc != 2) begin n_bad++; $display("FAIL div1_accepts: got %0d want 2", acc); end
        n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL div1_ready_vs_busy: got %0d bad cycles want 0", viol); end
        n_cmp++; if (nrx != 2) begin n_bad++; $display("FAIL div1_rx_pulses: got %0d want 2", nrx); end
        n_cmp++; if (rxd[0] !== 8'h96) begin n_bad++; $display("FAIL div1_rx0: got %h want 96", rxd[0]); end
        n_cmp++; if (rxd[1] !== 8'h5A) begin n_bad++; $display("FAIL div1_rx1: got %h want 5a", rxd[1]); end
        n_cmp++; if (rises != 16) begin n_bad++; $display("FAIL div1_rises: got %0d want 16", rises); end
        n_cmp++; if (rise_cyc[1] - rise_cyc[0] != 2) begin n_bad++; $display("FAIL div1_sclk_period: got %0d want 2", rise_cyc[1] - rise_cyc[0]); end
        n_cmp++; if (rise_cyc[7] - rise_cyc[0] != 14) begin n_bad++; $display("FAIL div1_word_span: got %0d want 14", rise_cyc[7] - rise_cyc[0]); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_reset_abort();
        test_div1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter WIDTH, default 8, meaning word length in bits (>=2).
REQ-002 Parameter CLK_DIV, default 4, meaning sclk half-period in clk cycles (>=1).
REQ-003 Parameter CPOL, default 0, meaning sclk idle level.
REQ-004 Parameter CPHA, default 0, meaning 0: sample on leading edge; 1: sample on trailing edge.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 tx_data  input  WIDTH  word to transmit, MSB first.
REQ-008 tx_last  input  1  deassert cs_n after this word.
REQ-009 tx_valid  input  1  tx_data/tx_last valid.
REQ-010 tx_ready  output  1  master can accept a word.
REQ-011 rx_data  output  WIDTH  last received word.
REQ-012 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 sclk  output  1  SPI clock.
REQ-015 mosi  output  1  serial data out.
REQ-016 miso  input  1  serial data in, pre-synchronized by integrator.
REQ-017 cs_n  output  1  active-low chip select.

Function
REQ-018 The states SHALL be IDLE, SETUP, XFER and HOLD; tx_ready SHALL be 1 only in IDLE.
REQ-019 On tx_valid&&tx_ready (cycle T), the block SHALL latch tx_data/tx_last into a shift register; the word SHALL be ignored when tx_ready=0.
REQ-020 If cs_n=1 at T, the block SHALL enter SETUP at T+1 with cs_n=0, remain CLK_DIV cycles, then enter XFER.
REQ-021 If cs_n=0 at T (previous word had tx_last=0), the block SHALL enter XFER directly at T+1.
REQ-022 With CPHA=0, mosi SHALL present the MSB from the first cycle of SETUP, or of XFER when SETUP is skipped.
REQ-023 In XFER, sclk SHALL toggle every CLK_DIV cycles; the first toggle SHALL occur CLK_DIV cycles after XFER entry, for exactly 2*WIDTH edges.
REQ-024 CPHA=0: miso SHALL be sampled on each leading edge; mosi SHALL shift to the next bit on each trailing edge except the last.
REQ-025 CPHA=1: mosi SHALL shift to the next bit on each leading edge, the first leading edge presenting the MSB; miso SHALL be sampled on each trailing edge.
REQ-026 Received bits SHALL shift in MSB first; rx_data SHALL update and rx_valid SHALL pulse for 1 cycle in the cycle after the final edge.
REQ-027 After the final edge, sclk SHALL equal CPOL.
REQ-028 rx_valid SHALL have no backpressure; consuming it is the user's responsibility.
REQ-029 After the final edge with latched tx_last=1, the block SHALL enter HOLD for CLK_DIV cycles with cs_n=0, then set cs_n=1 and enter IDLE.
REQ-030 After the final edge with latched tx_last=0, the block SHALL enter IDLE with cs_n held 0.
REQ-031 When cs_n=1, mosi SHALL be 0; when idle between words with cs_n=0, mosi SHALL hold its last value.
REQ-032 busy SHALL be 0 in IDLE and 1 otherwise.
REQ-033 The divider and bit counters SHALL be sized $clog2 of their terminal counts and SHALL clear on each state entry.

Reset
REQ-034 While rst_n=0 at a clock edge, the next state SHALL be IDLE with sclk=CPOL, cs_n=1, mosi=0, rx_data=0, rx_valid=0, busy=0, and all counters 0.
REQ-035 A reset mid-transfer SHALL abort the transfer on the next edge, produce no rx_valid pulse, and drive cs_n=1.
REQ-036 tx_valid SHALL be ignored while rst_n=0.

Verification
REQ-037 WIDTH=8, CLK_DIV=2, mode 0; send 0xA5 with last=1, loopback miso=mosi -> cs_n low T+1; first sclk rise at T+5; 16 edges; rx_valid with rx_data=0xA5; cs_n high 2 cycles after the final edge.
REQ-038 Mode 3 (CPOL=1, CPHA=1); slave model returns 0x3C for tx 0xC3 -> sclk idles 1; rx_data=0x3C; mosi bit sequence 1,1,0,0,0,0,1,1.
REQ-039 Send 0x11 (last=0) then 0x22 (last=1) back-to-back -> cs_n stays 0 between words, no SETUP on the second word, two rx_valid pulses, cs_n rises once.
REQ-040 Assert rst_n=0 during the 4th bit -> next cycle cs_n=1, sclk=CPOL, mosi=0, no rx_valid, tx_ready=1 after release.
REQ-041 CLK_DIV=1, tx_valid held high with last=1 -> tx_ready=0 during SETUP/XFER/HOLD; each word is accepted exactly once; sclk period is 2 clk cycles.
